// File: rtl/fp32_pkg.sv
// Shared FP32 constants and the reduction sequencer state encoding.
package fp32_pkg;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam int          FP_SIGN = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/FP_cong.sv
// Combinational FP32 adder: truncating alignment and normalisation, zero
// operands pass the other operand through, exact cancellation gives +0.
module FP_cong
    import fp32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic        a_zero, b_zero, a_ge, same_sign, sign_big;
    logic [7:0]  exp_big, exp_small, exp_diff;
    logic [23:0] mant_big, mant_small_full, mant_small;
    logic [24:0] sum;
    logic [23:0] diff;
    logic [4:0]  lz;
    logic        lz_found;
    logic [22:0] norm_frac;

    assign a_zero    = (a[30:23] == 8'd0);
    assign b_zero    = (b[30:23] == 8'd0);
    assign a_ge      = (a[30:0] >= b[30:0]);
    assign same_sign = (a[FP_SIGN] == b[FP_SIGN]);
    assign sign_big  = a_ge ? a[FP_SIGN] : b[FP_SIGN];

    assign exp_big         = a_ge ? a[30:23] : b[30:23];
    assign exp_small       = a_ge ? b[30:23] : a[30:23];
    assign exp_diff        = exp_big - exp_small;
    assign mant_big        = {1'b1, (a_ge ? a[22:0] : b[22:0])};
    assign mant_small_full = {1'b1, (a_ge ? b[22:0] : a[22:0])};
    // Bits shifted out of the smaller operand are simply dropped.
    assign mant_small      = (exp_diff >= 8'd24) ? 24'd0 : (mant_small_full >> exp_diff);

    assign sum  = {1'b0, mant_big} + {1'b0, mant_small};
    assign diff = mant_big - mant_small;

    always_comb begin
        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lz_found && diff[i]) begin
                lz       = 5'(23 - i);
                lz_found = 1'b1;
            end
        end
    end

    assign norm_frac = 23'(diff << lz);

    always_comb begin
        y = FP_ZERO;
        if (a_zero) begin
            y = b;
        end else if (b_zero) begin
            y = a;
        end else if (same_sign) begin
            if (sum[24])
                y = {sign_big, exp_big + 8'd1, sum[23:1]};
            else
                y = {sign_big, exp_big, sum[22:0]};
        end else if (diff == 24'd0 || {3'b000, lz} >= exp_big) begin
            // Cancellation or underflow past the normal range flushes to +0.
            y = FP_ZERO;
        end else begin
            y = {sign_big, exp_big - {3'b000, lz}, norm_frac};
        end
    end

endmodule

// File: rtl/fp_acc_seq.sv
// Reduction sequencer: acc = bias + sum of len streamed FP32 operands,
// one accumulate per clock, result presented with optional ReLU clamp.
module fp_acc_seq
    import fp32_pkg::*;
#(
    parameter int          LEN_W     = 16,
    parameter logic [31:0] RELU_ZERO = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      bias,
    input  logic [LEN_W-1:0] len,
    input  logic             relu_en,
    output logic             busy,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic [LEN_W-1:0] count
);

    // Stream handshakes: a transfer happens on a rising edge where both
    // valid and ready are high; valid/data must hold until that edge.

    state_t           state, state_nx;
    logic [31:0]      acc, add_y;
    logic [LEN_W-1:0] cnt, len_q;
    logic             relu_q;
    logic             in_fire, last_fire;

    FP_cong u_add (
        .a (acc),
        .b (in_data),
        .y (add_y)
    );

    assign in_fire   = in_valid && in_ready;
    assign last_fire = in_fire && (cnt == len_q - LEN_W'(1));
    assign count     = cnt;

    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = FP_ZERO;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = (len == '0) ? OUT : ACC;
            end
            ACC: begin
                in_ready = 1'b1;
                if (last_fire)
                    state_nx = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                out_data  = (relu_q && acc[FP_SIGN]) ? RELU_ZERO : acc;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= FP_ZERO;
            cnt    <= '0;
            len_q  <= '0;
            relu_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                acc    <= bias;
                len_q  <= len;
                relu_q <= relu_en;
                cnt    <= '0;
            end else if (in_fire) begin
                acc <= add_y;
                cnt <= cnt + LEN_W'(1);
            end
        end
    end

endmodule
